loop_div_ctrl: RTL and testbench

//  Sequencer for the programmable PLL loop divider's 6-bit ratio input div_n.
//  - Accepts a new integer/fractional ratio through a valid/ready handshake.
//  - Ramps the integer ratio toward the target in bounded steps.
//  - Dithers N/N+1 with a first-order accumulator for fractional-N operation.
//  - Changes div_n only on divider wrap ticks, so the loop never sees a mid-cycle ratio change.

---
 rtl/loop_div_ctrl.sv | 151 +++++++++++++++
 tb/tb_loop_div_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/loop_div_ctrl.sv
// PLL loop-divider ratio sequencer: accepts a new integer/fractional target,
// ramps div_n toward it in bounded steps and dithers N/N+1, updating only on wrap ticks.
module loop_div_ctrl #(
    parameter int N_W          = 6,
    parameter int FRAC_W       = 8,
    parameter int N_MIN        = 2,
    parameter int N_RESET      = 8,
    parameter int RAMP_STEP    = 1,
    parameter int SETTLE_TICKS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cyc_tick,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [N_W-1:0]    cfg_int,
    input  logic [FRAC_W-1:0] cfg_frac,
    input  logic              cfg_frac_en,
    output logic [N_W-1:0]    div_n,
    output logic              lock,
    output logic              cfg_err
);

    localparam int CNT_W = $clog2(SETTLE_TICKS + 1);
    localparam logic [N_W-1:0]   MIN_INT   = N_W'(N_MIN);
    localparam logic [N_W-1:0]   RST_INT   = N_W'(N_RESET);
    localparam logic [N_W-1:0]   STEP      = N_W'(RAMP_STEP);
    localparam logic [N_W-1:0]   MAX_DITH  = {{(N_W-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0] SETTLE_N  = CNT_W'(SETTLE_TICKS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAMP   = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t              r_state,      w_state_nxt;
    logic [N_W-1:0]      r_cur_int,    w_cur_int_nxt;
    logic [N_W-1:0]      r_tgt_int,    w_tgt_int_nxt;
    logic [FRAC_W-1:0]   r_tgt_frac,   w_tgt_frac_nxt;
    logic                r_frac_en,    w_frac_en_nxt;
    logic [FRAC_W-1:0]   r_acc,        w_acc_nxt;
    logic [CNT_W-1:0]    r_settle_cnt, w_settle_cnt_nxt;
    logic [N_W-1:0]      r_div_n,      w_div_n_nxt;
    logic                r_cfg_err,    w_cfg_err_nxt;

    logic                w_accept;
    logic                w_legal;
    logic [FRAC_W:0]     w_sum;
    logic                w_up;
    logic [N_W-1:0]      w_dist;
    logic [CNT_W-1:0]    w_cnt_inc;

    assign w_accept  = cfg_valid && (r_state == IDLE);
    assign w_legal   = (cfg_int >= MIN_INT) && (!cfg_frac_en || (cfg_int <= MAX_DITH));
    assign w_sum     = {1'b0, r_acc} + {1'b0, r_tgt_frac};
    assign w_up      = (r_tgt_int > r_cur_int);
    assign w_dist    = w_up ? (r_tgt_int - r_cur_int) : (r_cur_int - r_tgt_int);
    assign w_cnt_inc = r_settle_cnt + CNT_W'(1);

    // NOTE: every signal gets a hold default first, so no path through the
    // case/if tree leaves a variable unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt      = r_state;
        w_cur_int_nxt    = r_cur_int;
        w_tgt_int_nxt    = r_tgt_int;
        w_tgt_frac_nxt   = r_tgt_frac;
        w_frac_en_nxt    = r_frac_en;
        w_acc_nxt        = r_acc;
        w_settle_cnt_nxt = r_settle_cnt;
        w_div_n_nxt      = r_div_n;
        w_cfg_err_nxt    = 1'b0;

        if (cyc_tick) begin
            case (r_state)
                RAMP: begin
                    if (w_dist <= STEP) begin
                        w_cur_int_nxt    = r_tgt_int;
                        w_state_nxt      = SETTLE;
                        w_settle_cnt_nxt = '0;
                    end else if (w_up) begin
                        w_cur_int_nxt = r_cur_int + STEP;
                    end else begin
                        w_cur_int_nxt = r_cur_int - STEP;
                    end
                    w_div_n_nxt = w_cur_int_nxt;
                end
                default: begin
                    if (r_frac_en) begin
                        w_acc_nxt   = w_sum[FRAC_W-1:0];
                        w_div_n_nxt = r_cur_int + {{(N_W-1){1'b0}}, w_sum[FRAC_W]};
                    end else begin
                        w_acc_nxt   = '0;
                        w_div_n_nxt = r_cur_int;
                    end
                    if (r_state == SETTLE) begin
                        w_settle_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == SETTLE_N) w_state_nxt = IDLE;
                    end
                end
            endcase
        end

        // A coincident tick already used the old settings above; the new target
        // takes effect from the next tick. cur_int never moves on an IDLE tick.
        if (w_accept) begin
            if (w_legal) begin
                w_tgt_int_nxt    = cfg_int;
                w_tgt_frac_nxt   = cfg_frac;
                w_frac_en_nxt    = cfg_frac_en;
                w_acc_nxt        = '0;
                w_settle_cnt_nxt = '0;
                w_state_nxt      = (cfg_int != r_cur_int) ? RAMP : SETTLE;
            end else begin
                w_cfg_err_nxt = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= SETTLE;
            r_cur_int    <= RST_INT;
            r_tgt_int    <= RST_INT;
            r_tgt_frac   <= '0;
            r_frac_en    <= 1'b0;
            r_acc        <= '0;
            r_settle_cnt <= '0;
            r_div_n      <= RST_INT;
            r_cfg_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cur_int    <= w_cur_int_nxt;
            r_tgt_int    <= w_tgt_int_nxt;
            r_tgt_frac   <= w_tgt_frac_nxt;
            r_frac_en    <= w_frac_en_nxt;
            r_acc        <= w_acc_nxt;
            r_settle_cnt <= w_settle_cnt_nxt;
            r_div_n      <= w_div_n_nxt;
            r_cfg_err    <= w_cfg_err_nxt;
        end
    end

    assign cfg_ready = (r_state == IDLE);
    assign lock      = (r_state == IDLE);
    assign div_n     = r_div_n;
    assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_loop_div_ctrl.sv
// Scoreboard bench for loop_div_ctrl: each tick pushes the expected div_n/lock,
// a monitor pops and compares just after every ticked clock edge.
module tb_loop_div_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cyc_tick;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [5:0] cfg_int;
    logic [7:0] cfg_frac;
    logic       cfg_frac_en;
    logic [5:0] div_n;
    logic       lock;
    logic       cfg_err;

    typedef struct packed {
        logic [5:0] div;
        logic       lk;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    loop_div_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cyc_tick    (cyc_tick),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_int     (cfg_int),
        .cfg_frac    (cfg_frac),
        .cfg_frac_en (cfg_frac_en),
        .div_n       (div_n),
        .lock        (lock),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares after every clock edge that carried a tick.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (!rst && cyc_tick) begin
                #1;
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_underflow: tick with no expected entry (t=%0t)", $time);
                end else begin
                    e = sb_q.pop_front();
                    check("tick_div_n", int'(div_n), int'(e.div));
                    check("tick_lock", int'(lock), int'(e.lk));
                end
            end
        end
    end

    task automatic push_exp(input int d, input bit l);
        exp_t e;
        e.div = d[5:0];
        e.lk  = l;
        sb_q.push_back(e);
    endtask

    task automatic tick(input int d, input bit l);
        @(negedge clk);
        cyc_tick = 1'b1;
        push_exp(d, l);
        @(negedge clk);
        cyc_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_ready();
        int budget;
        budget = 0;
        while (!cfg_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!cfg_ready) check("ready_timeout", 0, 1);
    endtask

    task automatic send_cfg(input int n, input int f, input bit en, input bit exp_err);
        @(negedge clk);
        wait_ready();
        cfg_valid   = 1'b1;
        cfg_int     = n[5:0];
        cfg_frac    = f[7:0];
        cfg_frac_en = en;
        @(negedge clk);
        cfg_valid = 1'b0;
        check("cfg_err_pulse", int'(cfg_err), int'(exp_err));
        @(negedge clk);
        check("cfg_err_clear", int'(cfg_err), 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_div_n", int'(div_n), 8);
        check("rst_lock", int'(lock), 0);
        check("rst_ready", int'(cfg_ready), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        cyc_tick    = 1'b0;
        cfg_valid   = 1'b0;
        cfg_int     = '0;
        cfg_frac    = '0;
        cfg_frac_en = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_div_n", int'(div_n), 8);
        check("reset_lock", int'(lock), 0);
        check("reset_ready", int'(cfg_ready), 0);
        check("reset_err", int'(cfg_err), 0);
        rst = 1'b0;

        // Settle out of reset: lock only after the 4th tick.
        tick(8, 0); tick(8, 0); tick(8, 0); tick(8, 1);
        check("t1_ready", int'(cfg_ready), 1);

        // Integer ramp 8 -> 12, then 4 settle ticks.
        send_cfg(12, 0, 1'b0, 1'b0);
        check("t2_ready_busy", int'(cfg_ready), 0);
        tick(9, 0); tick(10, 0); tick(11, 0); tick(12, 0);
        tick(12, 0); tick(12, 0); tick(12, 0); tick(12, 1);

        // Ramp down to 10 to set up the dither case.
        send_cfg(10, 0, 1'b0, 1'b0);
        tick(11, 0); tick(10, 0);
        tick(10, 0); tick(10, 0); tick(10, 0); tick(10, 1);

        // Fractional 0x40 at the same integer: no ramp, carry every 4th tick.
        send_cfg(10, 'h40, 1'b1, 1'b0);
        tick(10, 0); tick(10, 0); tick(10, 0); tick(11, 1);
        tick(10, 1); tick(10, 1); tick(10, 1); tick(11, 1);

        // Illegal requests leave state, ready and div_n alone.
        send_cfg(1, 0, 1'b0, 1'b1);
        check("t4_div_hold", int'(div_n), 11);
        check("t4_ready_hold", int'(cfg_ready), 1);
        send_cfg(63, 0, 1'b1, 1'b1);
        check("t4_ready_hold2", int'(cfg_ready), 1);
        send_cfg(63, 0, 1'b0, 1'b0);
        check("t4_accept_63", int'(cfg_ready), 0);
        tick(11, 0); tick(12, 0);

        // Reset mid-ramp toward 63.
        pulse_reset();
        tick(8, 0); tick(8, 0); tick(8, 0); tick(8, 1);

        // Accept coincident with a tick: that tick still uses the old settings.
        @(negedge clk);
        cfg_valid   = 1'b1;
        cfg_int     = 6'd10;
        cfg_frac    = 8'd0;
        cfg_frac_en = 1'b0;
        cyc_tick    = 1'b1;
        push_exp(8, 0);
        @(negedge clk);
        cfg_valid = 1'b0;
        cyc_tick  = 1'b0;
        tick(9, 0); tick(10, 0);
        tick(10, 0); tick(10, 0); tick(10, 0); tick(10, 1);

        // Reset right after accepting 20 while div_n is 10.
        send_cfg(20, 0, 1'b0, 1'b0);
        check("t6_pre_div", int'(div_n), 10);
        check("t6_pre_lock", int'(lock), 0);
        pulse_reset();
        tick(8, 0); tick(8, 0); tick(8, 0); tick(8, 1);
        check("t6_ready", int'(cfg_ready), 1);

        repeat (3) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
